uart_rx_frame: RTL and testbench

Parametrised UART receive engine; successor to the fixed 8N1 receiver.
- Configurable data width, parity mode, stop-bit count and oversampling ratio.
- Samples each bit with a 3-point majority vote.
- Reports parity errors, framing errors and line-break conditions alongside each received word.
- Sits between the board RXD pin and the command/register-write logic; driven by the shared baud sample-enable generator.

---
 rtl/uart_pkg.sv | 25 ++
 rtl/uart_rx_sampler.sv | 65 ++++++
 rtl/uart_rx_frame.sv | 187 ++++++++++++++++++
 tb/tb_uart_rx_frame.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART receiver, transmitter and baud
// generator. It holds the parity mode codes, the receive FSM state type and
// the oversampling-ratio legality check.
package uart_pkg;

  localparam int unsigned PARITY_NONE = 0;
  localparam int unsigned PARITY_ODD  = 1;
  localparam int unsigned PARITY_EVEN = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_BRK_WAIT
  } rx_state_e;

  // An even ratio gives a centred midpoint; 8 is the minimum that keeps the
  // three vote points inside the bit.
  function automatic bit os_legal(input int unsigned os);
    return (os >= 8) && ((os % 2) == 0);
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// uart_rx_sampler: the front end of the UART receiver. It contains a 2-flop
// synchroniser, the per-bit tick counter and a 3-point majority voter.
//   clk, rst      system clock and asynchronous active-high reset
//   clk_smp_i     sample enable (OVERSAMPLE x baud)
//   rxd_i         raw serial input
//   restart_i     this tick is t=0 of a new start bit
//   rxd_s_o       synchronised line
//   vote_o        majority of the samples at t=M-1, M, M+1 (valid with strobe)
//   vote_stb_o    tick at t=M+1
//   bit_end_o     tick at t=OVERSAMPLE-1
module uart_rx_sampler #(
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clk_smp_i,
  input  logic rxd_i,
  input  logic restart_i,
  output logic rxd_s_o,
  output logic vote_o,
  output logic vote_stb_o,
  output logic bit_end_o
);

  localparam int unsigned TW  = $clog2(OVERSAMPLE);
  localparam int unsigned MID = OVERSAMPLE / 2;

  logic          sync1_q, sync2_q;
  logic          smp_a_q, smp_b_q;
  logic [TW-1:0] t_q, t_d;

  // A restart tick is t=0, so the following tick is t=1.
  always_comb begin
    t_d = t_q;
    if (clk_smp_i) begin
      if (restart_i)                        t_d = TW'(1);
      else if (t_q == TW'(OVERSAMPLE - 1))  t_d = '0;
      else                                  t_d = t_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      smp_a_q <= 1'b1;
      smp_b_q <= 1'b1;
      t_q     <= '0;
    end else begin
      t_q <= t_d;
      if (clk_smp_i) begin
        sync1_q <= rxd_i;
        sync2_q <= sync1_q;
        if (t_q == TW'(MID - 1)) smp_a_q <= sync2_q;
        if (t_q == TW'(MID))     smp_b_q <= sync2_q;
      end
    end
  end

  assign rxd_s_o    = sync2_q;
  assign vote_o     = (smp_a_q & smp_b_q) | (smp_a_q & sync2_q) | (smp_b_q & sync2_q);
  assign vote_stb_o = clk_smp_i && (t_q == TW'(MID + 1));
  assign bit_end_o  = clk_smp_i && (t_q == TW'(OVERSAMPLE - 1));

endmodule

// File: rtl/uart_rx_frame.sv
// uart_rx_frame: a parametrised UART receive engine. It provides a
// configurable data width, parity mode and stop-bit count, and it reports
// parity errors, framing errors and line-break conditions.
//   clk, rst     system clock and asynchronous active-high reset
//   clk_smp      sample enable, one clk pulse at OVERSAMPLE x baud
//   rxd          serial input; the line idles high
//   rxd_data     last received word, with the LSB received first
//   rxd_valid    one-clk pulse when a frame completes
//   parity_err   parity mismatch for the word in rxd_data
//   frame_err    a stop bit sampled 0 for the word in rxd_data
//   break_det    one-clk pulse when a line break is detected
module uart_rx_frame
  import uart_pkg::*;
#(
  parameter int unsigned DATA_BITS   = 8,
  parameter int unsigned PARITY_MODE = 0,
  parameter int unsigned STOP_BITS   = 1,
  parameter int unsigned OVERSAMPLE  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clk_smp,
  input  logic                 rxd,
  output logic [DATA_BITS-1:0] rxd_data,
  output logic                 rxd_valid,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 break_det
);

  if (!(DATA_BITS >= 5 && DATA_BITS <= 9) || (PARITY_MODE > 2) ||
      !(STOP_BITS == 1 || STOP_BITS == 2) || !os_legal(OVERSAMPLE)) begin : g_param_err
    $error("uart_rx_frame: illegal parameter set");
  end

  localparam int unsigned KW = $clog2(DATA_BITS);
  localparam int unsigned TW = $clog2(OVERSAMPLE);

  logic rxd_s, vote, vote_stb, bit_end, restart;

  rx_state_e            state_q, state_d;
  logic [KW-1:0]        k_q, k_d;
  logic                 stop_q, stop_d;
  logic [DATA_BITS-1:0] sr_q, sr_d;
  logic                 par_q, par_d;     // running XOR of the data votes
  logic                 zero_q, zero_d;   // every vote so far was 0
  logic                 perr_q, perr_d;
  logic                 ferr_q, ferr_d;
  logic [TW-1:0]        hi_q, hi_d;       // consecutive high ticks in BRK_WAIT
  logic                 complete, brk, p;

  assign restart = clk_smp && (state_q == ST_IDLE) && !rxd_s;

  uart_rx_sampler #(.OVERSAMPLE(OVERSAMPLE)) u_sampler (
    .clk        (clk),
    .rst        (rst),
    .clk_smp_i  (clk_smp),
    .rxd_i      (rxd),
    .restart_i  (restart),
    .rxd_s_o    (rxd_s),
    .vote_o     (vote),
    .vote_stb_o (vote_stb),
    .bit_end_o  (bit_end)
  );

  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    stop_d   = stop_q;
    sr_d     = sr_q;
    par_d    = par_q;
    zero_d   = zero_q;
    perr_d   = perr_q;
    ferr_d   = ferr_q;
    hi_d     = hi_q;
    complete = 1'b0;
    brk      = 1'b0;
    p        = par_q ^ vote;
    if (clk_smp) begin
      unique case (state_q)
        ST_IDLE: begin
          if (!rxd_s) begin
            state_d = ST_START;
            k_d     = '0;
            stop_d  = 1'b0;
            par_d   = 1'b0;
            zero_d  = 1'b1;
            perr_d  = 1'b0;
            ferr_d  = 1'b0;
          end
        end
        ST_START: begin
          if (vote_stb && vote) state_d = ST_IDLE;
          else if (bit_end)     state_d = ST_DATA;
        end
        ST_DATA: begin
          if (vote_stb) begin
            sr_d   = {vote, sr_q[DATA_BITS-1:1]};
            par_d  = par_q ^ vote;
            zero_d = zero_q & ~vote;
          end
          if (bit_end) begin
            if (k_q == KW'(DATA_BITS - 1))
              state_d = (PARITY_MODE != PARITY_NONE) ? ST_PARITY : ST_STOP;
            else
              k_d = k_q + 1'b1;
          end
        end
        ST_PARITY: begin
          if (vote_stb) begin
            perr_d = (PARITY_MODE == PARITY_ODD) ? ~p : p;
            zero_d = zero_q & ~vote;
          end
          if (bit_end) state_d = ST_STOP;
        end
        ST_STOP: begin
          // Leave on the final stop vote, not at the bit end, so the next
          // start edge is caught with half a bit of margin.
          if (vote_stb) begin
            if (!stop_q && zero_q && !vote) begin
              brk     = 1'b1;
              hi_d    = '0;
              state_d = ST_BRK_WAIT;
            end else begin
              if (!vote) ferr_d = 1'b1;
              if (stop_q == 1'(STOP_BITS - 1)) begin
                complete = 1'b1;
                state_d  = ST_IDLE;
              end else begin
                stop_d = 1'b1;
              end
            end
          end
        end
        ST_BRK_WAIT: begin
          if (rxd_s) begin
            if (hi_q == TW'(OVERSAMPLE - 1)) state_d = ST_IDLE;
            else                             hi_d = hi_q + 1'b1;
          end else begin
            hi_d = '0;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      k_q        <= '0;
      stop_q     <= 1'b0;
      sr_q       <= '0;
      par_q      <= 1'b0;
      zero_q     <= 1'b0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      hi_q       <= '0;
      rxd_data   <= '0;
      rxd_valid  <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      break_det  <= 1'b0;
    end else begin
      k_q       <= k_d;
      stop_q    <= stop_d;
      sr_q      <= sr_d;
      par_q     <= par_d;
      zero_q    <= zero_d;
      perr_q    <= perr_d;
      ferr_q    <= ferr_d;
      hi_q      <= hi_d;
      rxd_valid <= complete;
      break_det <= brk;
      if (complete) begin
        rxd_data   <= sr_q;
        parity_err <= perr_d;
        frame_err  <= ferr_d;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_frame.sv
module tb_uart_rx_frame;

  typedef struct packed {
    logic       brk;
    logic [8:0] data;
    logic       pe;
    logic       fe;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic clk_smp = 1'b0;
  logic rx0 = 1'b1, rx1 = 1'b1, rx2 = 1'b1, rx3 = 1'b1;
  logic [7:0] d0, d1, d2;
  logic [6:0] d3;
  logic v0, v1, v2, v3, pe0, pe1, pe2, pe3, fe0, fe1, fe2, fe3, bk0, bk1, bk2, bk3;

  int total = 0;
  int bad   = 0;
  int smp_div = 1;
  int smp_cnt = 0;

  exp_t q0[$], q1[$], q2[$], q3[$];

  always #5 clk = ~clk;

  always @(negedge clk) begin
    smp_cnt = (smp_cnt + 1 >= smp_div) ? 0 : smp_cnt + 1;
    clk_smp = (smp_cnt == 0);
  end

  // A: 8N1/16x   B: 8E1/16x   C: 8N2/16x   D: 7O1/8x
  uart_rx_frame u_a (
    .clk(clk), .rst(rst), .clk_smp(clk_smp), .rxd(rx0), .rxd_data(d0), .rxd_valid(v0),
    .parity_err(pe0), .frame_err(fe0), .break_det(bk0));
  uart_rx_frame #(.PARITY_MODE(2)) u_b (
    .clk(clk), .rst(rst), .clk_smp(clk_smp), .rxd(rx1), .rxd_data(d1), .rxd_valid(v1),
    .parity_err(pe1), .frame_err(fe1), .break_det(bk1));
  uart_rx_frame #(.STOP_BITS(2)) u_c (
    .clk(clk), .rst(rst), .clk_smp(clk_smp), .rxd(rx2), .rxd_data(d2), .rxd_valid(v2),
    .parity_err(pe2), .frame_err(fe2), .break_det(bk2));
  uart_rx_frame #(.DATA_BITS(7), .PARITY_MODE(1), .OVERSAMPLE(8)) u_d (
    .clk(clk), .rst(rst), .clk_smp(clk_smp), .rxd(rx3), .rxd_data(d3), .rxd_valid(v3),
    .parity_err(pe3), .frame_err(fe3), .break_det(bk3));

  task automatic chk(input string name, input logic [8:0] act, input logic [8:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input int i, input logic brk, input logic [8:0] data,
                      input logic pe, input logic fe);
    exp_t e;
    e = '{brk: brk, data: data, pe: pe, fe: fe};
    case (i)
      0: q0.push_back(e);
      1: q1.push_back(e);
      2: q2.push_back(e);
      default: q3.push_back(e);
    endcase
  endtask

  // Monitor: every valid or break pulse consumes one expected entry.
  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      logic vl, bk, pe, fe, empty;
      logic [8:0] dat;
      exp_t e;
      case (i)
        0: begin vl = v0; bk = bk0; pe = pe0; fe = fe0; dat = {1'b0, d0}; empty = (q0.size() == 0); end
        1: begin vl = v1; bk = bk1; pe = pe1; fe = fe1; dat = {1'b0, d1}; empty = (q1.size() == 0); end
        2: begin vl = v2; bk = bk2; pe = pe2; fe = fe2; dat = {1'b0, d2}; empty = (q2.size() == 0); end
        default: begin vl = v3; bk = bk3; pe = pe3; fe = fe3; dat = {2'b0, d3}; empty = (q3.size() == 0); end
      endcase
      if (vl || bk) begin
        if (empty) begin
          total++;
          bad++;
          $display("FAIL unexpected_pulse inst=%0d valid=%b break=%b data=%h at %0t",
                   i, vl, bk, dat, $time);
        end else begin
          case (i)
            0: e = q0.pop_front();
            1: e = q1.pop_front();
            2: e = q2.pop_front();
            default: e = q3.pop_front();
          endcase
          chk($sformatf("inst%0d_kind_valid", i), {8'b0, vl}, {8'b0, ~e.brk});
          chk($sformatf("inst%0d_kind_break", i), {8'b0, bk}, {8'b0, e.brk});
          chk($sformatf("inst%0d_data", i), dat, e.data);
          chk($sformatf("inst%0d_parity_err", i), {8'b0, pe}, {8'b0, e.pe});
          chk($sformatf("inst%0d_frame_err", i), {8'b0, fe}, {8'b0, e.fe});
        end
      end
    end
  end

  task automatic tick();
    do @(posedge clk); while (!clk_smp);
    #1;
  endtask

  task automatic set_rx(input int i, input logic v);
    case (i)
      0: rx0 = v;
      1: rx1 = v;
      2: rx2 = v;
      default: rx3 = v;
    endcase
  endtask

  task automatic idle(input int n);
    rx0 = 1'b1; rx1 = 1'b1; rx2 = 1'b1; rx3 = 1'b1;
    repeat (n) tick();
  endtask

  // Frame = start, nb data bits LSB first, optional parity, nstop stop bits.
  // gl marks frame bit positions that get a 1-tick inverted glitch mid-bit.
  task automatic send_frame(input int i, input int os, input int nb, input logic [8:0] d,
                            input int haspar, input logic pbit, input int nstop,
                            input logic [1:0] stops, input logic [15:0] gl);
    logic [15:0] bits;
    int n;
    bits = '0;
    n = 0;
    bits[n] = 1'b0; n++;
    for (int b = 0; b < nb; b++) begin bits[n] = d[b]; n++; end
    if (haspar != 0) begin bits[n] = pbit; n++; end
    for (int s = 0; s < nstop; s++) begin bits[n] = stops[s]; n++; end
    for (int j = 0; j < n; j++) begin
      for (int k = 0; k < os; k++) begin
        set_rx(i, (gl[j] && k == os / 2) ? ~bits[j] : bits[j]);
        tick();
      end
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_d0"}, {1'b0, d0}, 9'h0);
    chk({tag, "_d1"}, {1'b0, d1}, 9'h0);
    chk({tag, "_d2"}, {1'b0, d2}, 9'h0);
    chk({tag, "_d3"}, {2'b0, d3}, 9'h0);
    chk({tag, "_valid"}, {5'b0, v3, v2, v1, v0}, 9'h0);
    chk({tag, "_break"}, {5'b0, bk3, bk2, bk1, bk0}, 9'h0);
    chk({tag, "_perr"}, {5'b0, pe3, pe2, pe1, pe0}, 9'h0);
    chk({tag, "_ferr"}, {5'b0, fe3, fe2, fe1, fe0}, 9'h0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset");
    rst = 1'b0;
    idle(20);
    chk_all_zero("post_reset");

    // 1: 8N1, clk_smp every clk
    push(0, 1'b0, 9'h0A5, 1'b0, 1'b0);
    send_frame(0, 16, 8, 9'h0A5, 0, 1'b0, 1, 2'b11, 16'h0);
    push(0, 1'b0, 9'h03C, 1'b0, 1'b0);   // back-to-back, no idle gap
    send_frame(0, 16, 8, 9'h03C, 0, 1'b0, 1, 2'b11, 16'h0);
    idle(20);

    // 2: even parity, clk_smp every third clk
    smp_div = 3;
    push(1, 1'b0, 9'h05A, 1'b1, 1'b0);
    send_frame(1, 16, 8, 9'h05A, 1, 1'b1, 1, 2'b11, 16'h0);
    push(1, 1'b0, 9'h05A, 1'b0, 1'b0);
    send_frame(1, 16, 8, 9'h05A, 1, 1'b0, 1, 2'b11, 16'h0);
    idle(20);

    // 3: two stop bits, second one low
    push(2, 1'b0, 9'h03C, 1'b0, 1'b1);
    send_frame(2, 16, 8, 9'h03C, 0, 1'b0, 2, 2'b01, 16'h0);
    idle(40);
    push(2, 1'b0, 9'h03C, 1'b0, 1'b0);
    send_frame(2, 16, 8, 9'h03C, 0, 1'b0, 2, 2'b11, 16'h0);
    idle(20);
    smp_div = 1;
    idle(4);

    // 4: noise rejection
    rx0 = 1'b0;
    repeat (5) tick();
    idle(40);
    push(0, 1'b0, 9'h096, 1'b0, 1'b0);
    send_frame(0, 16, 8, 9'h096, 0, 1'b0, 1, 2'b11, 16'h01FE);
    idle(20);

    // 5: line break for 12 bit times
    push(0, 1'b1, 9'h096, 1'b0, 1'b0);
    rx0 = 1'b0;
    repeat (12 * 16) tick();
    idle(40);
    push(0, 1'b0, 9'h081, 1'b0, 1'b0);
    send_frame(0, 16, 8, 9'h081, 0, 1'b0, 1, 2'b11, 16'h0);
    idle(20);

    // 6: 7O1/8x: bad parity first, then reset in the middle of a frame
    push(3, 1'b0, 9'h055, 1'b1, 1'b0);
    send_frame(3, 8, 7, 9'h055, 1, 1'b0, 1, 2'b11, 16'h0);
    idle(20);
    rx3 = 1'b0;
    repeat (8) tick();
    rx3 = 1'b1;
    repeat (3 * 8) tick();
    rst = 1'b1;
    #1;
    chk_all_zero("mid_frame_reset");
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    idle(30);
    chk_all_zero("after_abort");
    push(3, 1'b0, 9'h042, 1'b0, 1'b0);
    send_frame(3, 8, 7, 9'h042, 1, 1'b1, 1, 2'b11, 16'h0);
    idle(40);

    chk("pending0", 9'(q0.size()), 9'h0);
    chk("pending1", 9'(q1.size()), 9'h0);
    chk("pending2", 9'(q2.size()), 9'h0);
    chk("pending3", 9'(q3.size()), 9'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
